// File: rtl/acc_datapath_pkg.sv
// acc_datapath_pkg: shared encodings for the accumulator datapath and its multiplier.
package acc_datapath_pkg;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_XOR   = 3'b100,
        ALU_SHL1  = 3'b101,
        ALU_SAR1  = 3'b110,
        ALU_PASSB = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        SEL_A_MEM = 2'b00,
        SEL_A_EXT = 2'b01,
        SEL_A_ALU = 2'b10,
        SEL_A_MUL = 2'b11
    } sel_a_t;

    typedef enum logic {
        SEL_B_MEM = 1'b0,
        SEL_B_EXT = 1'b1
    } sel_b_t;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_RUN  = 1'b1
    } mul_state_t;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/acc_datapath_seq_multiplier.sv
// seq_multiplier: shift-add multiplier, one multiplier bit per cycle, low-half result.
module seq_multiplier
    import acc_datapath_pkg::*;
#(
    parameter int DATA_WIDTH = 11
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  start_in,
    input  logic [DATA_WIDTH-1:0] multiplicand_in,
    input  logic [DATA_WIDTH-1:0] multiplier_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [DATA_WIDTH-1:0] result_out
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    mul_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [DATA_WIDTH-1:0] prod_q, prod_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  done_q, done_d;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        case (state_q)
            MUL_IDLE: if (start_in) begin
                state_d  = MUL_RUN;
                mcand_d  = multiplicand_in;
                mplier_d = multiplier_in;
                prod_d   = '0;
                cnt_d    = CNT_W'(DATA_WIDTH);
            end
            MUL_RUN: begin
                prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
                // The final iteration's sum is latched directly so done and result coincide.
                if (cnt_d == '0) begin
                    state_d  = MUL_IDLE;
                    result_d = prod_d;
                    done_d   = 1'b1;
                end
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q  <= MUL_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign busy_out   = (state_q == MUL_RUN);
    assign done_out   = done_q;
    assign result_out = result_q;

endmodule

// File: rtl/acc_datapath.sv
// acc_datapath: accumulator bank, 8-op ALU with Z/N/C/V flags, immediate path and sequential multiplier.
module acc_datapath
    import acc_datapath_pkg::*;
#(
    parameter int DATA_WIDTH = 11,
    parameter int ACC_COUNT  = 2,
    parameter int IMM_WIDTH  = 8
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic [DATA_WIDTH-1:0]        operand_in,
    input  logic [DATA_WIDTH-1:0]        data_memory_in,
    input  logic [$clog2(ACC_COUNT)-1:0] acc_sel_in,
    input  logic [2:0]                   alu_op_in,
    input  logic [1:0]                   sel_A_in,
    input  logic                         sel_B_in,
    input  logic                         acc_wr_in,
    input  logic                         status_wr_in,
    input  logic                         mul_start_in,
    output logic                         mul_busy_out,
    output logic                         mul_done_out,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic [DATA_WIDTH-1:0]        ext_out,
    output logic [DATA_WIDTH-1:0]        data_memory_address_out,
    output logic                         flag_Z_out,
    output logic                         flag_N_out,
    output logic                         flag_C_out,
    output logic                         flag_V_out
);

    localparam int M = DATA_WIDTH - 1;

    logic [DATA_WIDTH-1:0] acc_q [ACC_COUNT];
    logic [DATA_WIDTH-1:0] acc_d [ACC_COUNT];
    flags_t                flags_q, flags_d, alu_flags;
    alu_op_t               alu_op;
    logic                  acc_sel_ok;
    logic [DATA_WIDTH-1:0] acc_a, ext, mux_b, b_eff, alu_res, mux_a, mul_result;
    logic [DATA_WIDTH:0]   sum;
    logic                  alu_c, alu_v;

    assign alu_op     = alu_op_t'(alu_op_in);
    assign acc_sel_ok = int'(acc_sel_in) < ACC_COUNT;
    assign acc_a      = acc_sel_ok ? acc_q[acc_sel_in] : '0;
    assign ext        = DATA_WIDTH'($signed(operand_in[IMM_WIDTH-1:0]));
    assign mux_b      = (sel_b_t'(sel_B_in) == SEL_B_EXT) ? ext : data_memory_in;

    // SUB shares the adder as A + ~B + 1, so C=1 means no borrow.
    assign b_eff = (alu_op == ALU_SUB) ? ~mux_b : mux_b;
    assign sum   = {1'b0, acc_a} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, alu_op == ALU_SUB};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (alu_op)
            ALU_ADD, ALU_SUB: begin
                alu_res = sum[M:0];
                alu_c   = sum[DATA_WIDTH];
                alu_v   = (acc_a[M] == b_eff[M]) && (alu_res[M] != acc_a[M]);
            end
            ALU_AND:   alu_res = acc_a & mux_b;
            ALU_OR:    alu_res = acc_a | mux_b;
            ALU_XOR:   alu_res = acc_a ^ mux_b;
            ALU_SHL1: begin
                alu_res = {acc_a[M-1:0], 1'b0};
                alu_c   = acc_a[M];
            end
            ALU_SAR1: begin
                alu_res = {acc_a[M], acc_a[M:1]};
                alu_c   = acc_a[0];
            end
            default:   alu_res = mux_b;
        endcase
    end

    assign alu_flags = '{z: alu_res == '0, n: alu_res[M], c: alu_c, v: alu_v};

    always_comb begin
        case (sel_a_t'(sel_A_in))
            SEL_A_MEM: mux_a = data_memory_in;
            SEL_A_EXT: mux_a = ext;
            SEL_A_ALU: mux_a = alu_res;
            default:   mux_a = mul_result;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        if (acc_wr_in && acc_sel_ok) acc_d[acc_sel_in] = mux_a;
    end

    assign flags_d = status_wr_in ? alu_flags : flags_q;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            acc_q   <= '{default: '0};
            flags_q <= '0;
        end else begin
            acc_q   <= acc_d;
            flags_q <= flags_d;
        end
    end

    seq_multiplier #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mul (
        .clock_in        (clock_in),
        .reset_in        (reset_in),
        .start_in        (mul_start_in),
        .multiplicand_in (acc_a),
        .multiplier_in   (mux_b),
        .busy_out        (mul_busy_out),
        .done_out        (mul_done_out),
        .result_out      (mul_result)
    );

    assign data_out                = acc_a;
    assign ext_out                 = ext;
    assign data_memory_address_out = operand_in;
    assign flag_Z_out              = flags_q.z;
    assign flag_N_out              = flags_q.n;
    assign flag_C_out              = flags_q.c;
    assign flag_V_out              = flags_q.v;

endmodule

// File: tb/tb_acc_datapath.sv
// tb_acc_datapath: directed scenarios plus random cycles against an arithmetic reference model.
module tb_acc_datapath;

    localparam int DW = 11;
    localparam int N  = 2;
    localparam int IW = 8;
    localparam int unsigned MASK = (1 << DW) - 1;
    localparam int HI = (1 << (DW - 1)) - 1;
    localparam int LO = -(1 << (DW - 1));

    logic          clock_in = 1'b0;
    logic          reset_in;
    logic [DW-1:0] operand_in, data_memory_in;
    logic [0:0]    acc_sel_in;
    logic [2:0]    alu_op_in;
    logic [1:0]    sel_A_in;
    logic          sel_B_in, acc_wr_in, status_wr_in, mul_start_in;
    logic          mul_busy_out, mul_done_out;
    logic [DW-1:0] data_out, ext_out, data_memory_address_out;
    logic          flag_Z_out, flag_N_out, flag_C_out, flag_V_out;

    acc_datapath #(.DATA_WIDTH(DW), .ACC_COUNT(N), .IMM_WIDTH(IW)) dut (
        .clock_in                (clock_in),
        .reset_in                (reset_in),
        .operand_in              (operand_in),
        .data_memory_in          (data_memory_in),
        .acc_sel_in              (acc_sel_in),
        .alu_op_in               (alu_op_in),
        .sel_A_in                (sel_A_in),
        .sel_B_in                (sel_B_in),
        .acc_wr_in               (acc_wr_in),
        .status_wr_in            (status_wr_in),
        .mul_start_in            (mul_start_in),
        .mul_busy_out            (mul_busy_out),
        .mul_done_out            (mul_done_out),
        .data_out                (data_out),
        .ext_out                 (ext_out),
        .data_memory_address_out (data_memory_address_out),
        .flag_Z_out              (flag_Z_out),
        .flag_N_out              (flag_N_out),
        .flag_C_out              (flag_C_out),
        .flag_V_out              (flag_V_out)
    );

    always #5 clock_in = ~clock_in;

    int checks = 0;
    int errors = 0;

    int unsigned m_acc [N];
    bit [3:0]    m_flags;
    bit          m_busy, m_done;
    int          m_cnt;
    int unsigned m_pend, m_res;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sx(input int unsigned v);
        return ((v >> (DW - 1)) & 1) != 0 ? int'(v) - (1 << DW) : int'(v);
    endfunction

    function automatic int unsigned ext_of(input int unsigned opnd);
        int unsigned e;
        e = opnd & ((1 << IW) - 1);
        if (((e >> (IW - 1)) & 1) != 0) e = e | (MASK & ~((1 << IW) - 1));
        return e;
    endfunction

    task automatic drive(input int sel, input int op, input int sa, input int sb, input bit wr,
                         input bit swr, input bit st, input int unsigned opnd, input int unsigned mem,
                         input bit rst);
        acc_sel_in     = 1'(sel);
        alu_op_in      = 3'(op);
        sel_A_in       = 2'(sa);
        sel_B_in       = 1'(sb);
        acc_wr_in      = wr;
        status_wr_in   = swr;
        mul_start_in   = st;
        operand_in     = DW'(opnd);
        data_memory_in = DW'(mem);
        reset_in       = rst;
    endtask

    task automatic step();
        int unsigned a, b, e, res, full, mux;
        int sr;
        bit c, v;
        e = ext_of(operand_in);
        a = m_acc[acc_sel_in];
        b = sel_B_in ? e : int'(data_memory_in);
        c = 0;
        v = 0;
        full = 0;
        sr = 0;
        case (alu_op_in)
            3'd0: begin full = a + b; sr = sx(a) + sx(b); end
            3'd1: begin full = a + (~b & MASK) + 1; sr = sx(a) - sx(b); end
            default: ;
        endcase
        case (alu_op_in)
            3'd0, 3'd1: begin
                res = full & MASK;
                c = ((full >> DW) & 1) != 0;
                v = sr > HI || sr < LO;
            end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: begin res = (a << 1) & MASK; c = ((a >> (DW - 1)) & 1) != 0; end
            3'd6: begin res = (a >> 1) | (a & (1 << (DW - 1))); c = (a & 1) != 0; end
            default: res = b;
        endcase
        case (sel_A_in)
            2'd0: mux = data_memory_in;
            2'd1: mux = e;
            2'd2: mux = res;
            default: mux = m_res;
        endcase
        if (reset_in) begin
            foreach (m_acc[i]) m_acc[i] = 0;
            m_flags = 0;
            m_busy = 0;
            m_done = 0;
            m_cnt = 0;
            m_res = 0;
        end else begin
            if (acc_wr_in) m_acc[acc_sel_in] = mux;
            if (status_wr_in) m_flags = {res == 0, ((res >> (DW - 1)) & 1) != 0, c, v};
            m_done = 0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 0;
                    m_res = m_pend;
                    m_done = 1;
                end
            end else if (mul_start_in) begin
                m_busy = 1;
                m_cnt = DW;
                m_pend = (a * b) & MASK;
            end
        end
        @(posedge clock_in);
        #1;
        check("data_out", data_out, m_acc[acc_sel_in]);
        check("flags_zncv", {flag_Z_out, flag_N_out, flag_C_out, flag_V_out}, m_flags);
        check("busy", mul_busy_out, m_busy);
        check("done", mul_done_out, m_done);
        check("ext_out", ext_out, ext_of(operand_in));
        check("mem_addr", data_memory_address_out, operand_in);
    endtask

    function automatic logic [3:0] flags();
        return {flag_Z_out, flag_N_out, flag_C_out, flag_V_out};
    endfunction

    initial begin
        foreach (m_acc[i]) m_acc[i] = 0;
        m_flags = 0; m_busy = 0; m_done = 0; m_cnt = 0; m_pend = 0; m_res = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        check("reset_data", data_out, 0);
        check("reset_flags", flags(), 4'b0000);
        check("reset_busy_done", {mul_busy_out, mul_done_out}, 2'b00);

        // ADD overflow: 1023 + 1
        drive(0, 0, 0, 0, 1, 0, 0, 0, 1023, 0);
        step();
        drive(0, 0, 2, 0, 1, 1, 0, 0, 1, 0);
        step();
        check("add_ovf_acc", data_out, 'h400);
        check("add_ovf_flags", flags(), 4'b0101);

        // Equal SUB, then flags hold
        drive(0, 0, 1, 1, 1, 0, 0, 5, 0, 0);
        step();
        drive(0, 1, 0, 1, 0, 1, 0, 5, 0, 0);
        step();
        check("sub_eq_flags", flags(), 4'b1010);
        drive(0, 0, 0, 1, 0, 0, 0, 3, 0, 0);
        step();
        check("flags_hold", flags(), 4'b1010);

        // Bank isolation
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        drive(1, 0, 1, 1, 1, 0, 0, 7, 0, 0);
        step();
        check("bank_acc1", data_out, 7);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check("bank_acc0", data_out, 0);

        // 25 * -3
        drive(0, 0, 1, 1, 1, 0, 0, 25, 0, 0);
        step();
        drive(0, 0, 0, 1, 0, 0, 1, 'h0FD, 0, 0);
        step();
        check("mul_busy_e0", mul_busy_out, 1);
        mul_start_in = 0;
        for (int k = 1; k <= DW; k++) begin
            step();
            check("mul_busy_k", mul_busy_out, k < DW);
            check("mul_done_k", mul_done_out, k == DW);
        end
        drive(0, 0, 3, 1, 1, 0, 0, 'h0FD, 0, 0);
        step();
        check("mul_result", data_out, 'h7B5);

        // Start while busy ignored; start in done cycle accepted
        drive(0, 0, 0, 1, 0, 0, 1, 'h0FD, 0, 0);
        step();
        for (int k = 1; k <= DW; k++) begin
            mul_start_in = (k == 4);
            operand_in = (k == 4) ? DW'(9) : DW'('h0FD);
            step();
            check("rerun_done_k", mul_done_out, k == DW);
        end
        drive(0, 0, 0, 1, 0, 0, 1, 2, 0, 0);
        step();
        check("start_in_done_cycle", mul_busy_out, 1);
        mul_start_in = 0;
        for (int k = 1; k <= DW; k++) step();
        drive(0, 0, 3, 1, 1, 0, 0, 2, 0, 0);
        step();
        check("mul_second_result", data_out, 'h76A);

        // Reset mid-multiply
        drive(0, 0, 0, 1, 0, 1, 1, 'h0FD, 0, 0);
        step();
        mul_start_in = 0;
        for (int k = 1; k < 5; k++) step();
        reset_in = 1;
        step();
        check("abort_busy_done", {mul_busy_out, mul_done_out}, 2'b00);
        check("abort_flags", flags(), 4'b0000);
        drive(0, 0, 3, 1, 1, 0, 0, 0, 0, 0);
        step();
        check("abort_result", data_out, 0);
        check("abort_no_done", mul_done_out, 0);

        for (int i = 0; i < 2000; i++) begin
            drive(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 1)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 5) == 0, $urandom & MASK, $urandom & MASK,
                  $urandom_range(0, 63) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
